pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Front end of the IF stage: owns the program counter, drives the address port of the synchronous instruction memory and turns its one-cycle-latency output into the IF/ID view consumed by decode. The view is instruction, PC, PC+4 and valid. It absorbs decode stalls with a one-entry hold register, so a stall release costs no bubble. Branch/jump redirects from EX squash the in-flight fetch.

## Interface
- WIDTH, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP, 32'h0000_0013: instruction presented to decode when id_valid=0.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  decode cannot accept; hold the IF/ID view.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  WIDTH  redirect target.
- pc  out  WIDTH  address to instruction memory (registered, P).
- instr_mem  in  WIDTH  memory read data; equals mem[pc sampled at previous edge].
- id_instr  out  WIDTH  instruction to decode.
- id_pc  out  WIDTH  address of id_instr (registered, F).
- id_pc_plus4  out  WIDTH  id_pc + 4, modulo 2^WIDTH.
- id_valid  out  1  id_instr is a real instruction.
- fetch_misaligned  out  1  registered; 1 for one cycle after a redirect with redirect_pc[1:0] != 0.
- holding  out  1  state == HOLD.

## Operation
- Registers: P (pc), F (id_pc), f_valid (id_valid), hold_instr, state {RUN, HOLD}, fetch_misaligned.
- id_instr = !f_valid ? NOP : (state==HOLD ? hold_instr : instr_mem).
- Edge priority, highest first:
  - reset:
    - P<=RESET_PC, F<=0, f_valid<=0, state<=RUN.
    - hold_instr<=NOP, fetch_misaligned<=0.
  - redirect:
    - P<={redirect_pc[WIDTH-1:2],2'b00}, f_valid<=0, state<=RUN.
    - fetch_misaligned<=|redirect_pc[1:0].
    - F is don't-care and holds.
  - RUN, stall=1, f_valid=1: hold_instr<=instr_mem, state<=HOLD; P, F, f_valid hold.
  - HOLD, stall=1: all hold.
  - HOLD, stall=0: F<=P, P<=P+4, f_valid<=1, state<=RUN.
  - RUN, stall=0, or stall=1 with f_valid=0: F<=P, P<=P+4, f_valid<=1.
    - stall is ignored when nothing valid is presented, so a bubble may be overwritten.
- fetch_misaligned clears on any edge without a misaligned redirect.
- Behaviour while in HOLD:
  - Memory keeps reading mem[P], the next sequential instruction.
  - On release, instr_mem already holds mem[new F], so no re-fetch is needed.
- P+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000. No other arithmetic; id_pc_plus4 wraps identically.

## Timing
- Reset values: pc=RESET_PC, id_pc=0, id_pc_plus4=4, id_valid=0, id_instr=NOP, holding=0, fetch_misaligned=0.
- Fetch latency: address on pc at cycle n -> id_instr/id_pc valid at cycle n+1.
- After reset deassert:
  - First cycle: id_valid=0.
  - Next cycle: id_valid=1 with id_pc=RESET_PC.
  - Then one instruction per cycle.
- Redirect at edge n:
  - Cycle n+1: pc=target, id_valid=0 (one-cycle bubble).
  - Cycle n+2: id_pc=target.
- Stall:
  - First stalled cycle: output unchanged, holding=0; at that edge the view is captured.
  - Following stalled cycles: holding=1, outputs stable.
  - First unstalled cycle after HOLD: next sequential instruction, no bubble.
- redirect and stall in the same cycle: redirect wins, hold is discarded.
- reset mid-HOLD or mid-redirect: reset wins, reset values next cycle.

## Test plan
- Reset, RESET_PC=0x100, memory mem[i]=0x1000+i:
  - Cycle 1: id_valid=0, id_instr=0x13.
  - Then id_pc=0x100,0x104,0x108 with id_instr=mem[0x40],mem[0x41],mem[0x42]; id_pc_plus4=id_pc+4.
- Stall 3 cycles while id_pc=0x108:
  - id_instr/id_pc stable for all stalled cycles; holding=1 from the 2nd.
  - After release: id_pc=0x10C then 0x110, no bubble, no duplicate.
- Redirect to 0x200 while streaming:
  - Next cycle: pc=0x200, id_valid=0.
  - Following cycle: id_pc=0x200, id_instr=mem[0x80].
- Redirect to 0x203 with stall=1 in HOLD:
  - Redirect wins: pc=0x200, fetch_misaligned=1 for one cycle, holding=0.
- PC wrap: redirect to 0xFFFF_FFFC -> next pc=0x0000_0000; id_pc_plus4 of 0xFFFF_FFFC is 0.
- Reset asserted during HOLD -> next cycle all outputs at reset values; restart fetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// IF-stage front end: owns the PC, addresses sync imem, presents the IF/ID view.
// Latency: address on pc in cycle n -> id_instr/id_pc in cycle n+1; redirects cost one bubble.
// Backpressure: stall holds the view; a one-entry hold register makes release bubble-free.
module pc_fetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter logic [WIDTH-1:0]  NOP      = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] instr_mem,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic             id_valid,
    output logic             fetch_misaligned,
    output logic             holding
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            id_pc            <= '0;
            id_valid         <= 1'b0;
            state            <= RUN;
            hold_instr       <= NOP;
            fetch_misaligned <= 1'b0;
        end else begin
            fetch_misaligned <= 1'b0;
            if (redirect) begin
                pc               <= {redirect_pc[WIDTH-1:2], 2'b00};
                id_valid         <= 1'b0;
                state            <= RUN;
                fetch_misaligned <= |redirect_pc[1:0];
            end else if (state == RUN && stall && id_valid) begin
                // Memory moves on to mem[pc] next cycle, so capture the presented word now.
                hold_instr <= instr_mem;
                state      <= HOLD;
            end else if (state == HOLD && stall) begin
                state <= HOLD;
            end else begin
                // A stall against a bubble is ignored: nothing worth holding.
                id_pc    <= pc;
                pc       <= pc + WIDTH'(4);
                id_valid <= 1'b1;
                state    <= RUN;
            end
        end
    end

    always_comb begin
        id_instr = instr_mem;
        if (!id_valid)
            id_instr = NOP;
        else if (state == HOLD)
            id_instr = hold_instr;
    end

    assign id_pc_plus4 = id_pc + WIDTH'(4);
    assign holding     = (state == HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table of the fetch corner cases, then random stall/redirect/reset traffic vs an address-level model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc, pc, instr_mem, id_instr, id_pc, id_pc_plus4;
    logic        id_valid, fetch_misaligned, holding;

    int n_total = 0;
    int n_pass  = 0;

    // Reference view: next fetch address, presented address/valid, held flag.
    logic [31:0] m_pc, m_fpc;
    logic        m_v, m_held, m_mis;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(RPC), .NOP(NOPI)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .pc(pc), .instr_mem(instr_mem),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .id_valid(id_valid), .fetch_misaligned(fetch_misaligned), .holding(holding)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) instr_mem <= memf(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        if (r) begin
            m_pc = RPC; m_fpc = 32'h0; m_v = 1'b0; m_held = 1'b0; m_mis = 1'b0;
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_v = 1'b0; m_held = 1'b0; m_mis = |rpc[1:0];
        end else begin
            m_mis = 1'b0;
            if (s && m_v) begin
                m_held = 1'b1;
            end else begin
                m_fpc = m_pc; m_pc = m_pc + 32'd4; m_v = 1'b1; m_held = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        reset = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, s, rd, rpc);
        @(negedge clk);
    endtask

    typedef struct {
        logic        r, s, rd;
        logic [31:0] rpc;
        logic [31:0] e_pc, e_idpc, e_instr;
        logic        e_v, e_hold, e_mis;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                                input logic [31:0] e_pc, input logic [31:0] e_idpc, input logic e_v,
                                input logic [31:0] e_instr, input logic e_hold, input logic e_mis);
        vec_t v;
        v.r = r; v.s = s; v.rd = rd; v.rpc = rpc;
        v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_v = e_v; v.e_instr = e_instr;
        v.e_hold = e_hold; v.e_mis = e_mis;
        return v;
    endfunction

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        //           r  s  rd rpc            pc             id_pc          v  instr          hold mis
        vt[0]  = mk(1, 0, 0, 32'h0,        32'h100,       32'h0,         0, NOPI,          0, 0);
        vt[1]  = mk(0, 0, 0, 32'h0,        32'h104,       32'h100,       1, 32'h1040,      0, 0);
        vt[2]  = mk(0, 0, 0, 32'h0,        32'h108,       32'h104,       1, 32'h1041,      0, 0);
        vt[3]  = mk(0, 0, 0, 32'h0,        32'h10C,       32'h108,       1, 32'h1042,      0, 0);
        vt[4]  = mk(0, 1, 0, 32'h0,        32'h10C,       32'h108,       1, 32'h1042,      1, 0);
        vt[5]  = mk(0, 1, 0, 32'h0,        32'h10C,       32'h108,       1, 32'h1042,      1, 0);
        vt[6]  = mk(0, 1, 0, 32'h0,        32'h10C,       32'h108,       1, 32'h1042,      1, 0);
        vt[7]  = mk(0, 0, 0, 32'h0,        32'h110,       32'h10C,       1, 32'h1043,      0, 0);
        vt[8]  = mk(0, 0, 0, 32'h0,        32'h114,       32'h110,       1, 32'h1044,      0, 0);
        vt[9]  = mk(0, 0, 1, 32'h200,      32'h200,       32'h110,       0, NOPI,          0, 0);
        vt[10] = mk(0, 0, 0, 32'h0,        32'h204,       32'h200,       1, 32'h1080,      0, 0);
        vt[11] = mk(0, 1, 0, 32'h0,        32'h204,       32'h200,       1, 32'h1080,      1, 0);
        vt[12] = mk(0, 1, 1, 32'h203,      32'h200,       32'h200,       0, NOPI,          0, 1);
        vt[13] = mk(0, 0, 0, 32'h0,        32'h204,       32'h200,       1, 32'h1080,      0, 0);
        vt[14] = mk(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC,  32'h200,       0, NOPI,          0, 0);
        vt[15] = mk(0, 0, 0, 32'h0,        32'h0,         32'hFFFFFFFC,  1, 32'h40000FFF,  0, 0);
        vt[16] = mk(0, 0, 0, 32'h0,        32'h4,         32'h0,         1, 32'h1000,      0, 0);
        vt[17] = mk(0, 1, 0, 32'h0,        32'h4,         32'h0,         1, 32'h1000,      1, 0);
        vt[18] = mk(1, 1, 0, 32'h0,        32'h100,       32'h0,         0, NOPI,          0, 0);
        vt[19] = mk(0, 0, 0, 32'h0,        32'h104,       32'h100,       1, 32'h1040,      0, 0);

        for (int i = 0; i < 20; i++) begin
            cycle(vt[i].r, vt[i].s, vt[i].rd, vt[i].rpc);
            chk($sformatf("dir%0d.pc", i),      pc,               vt[i].e_pc);
            chk($sformatf("dir%0d.id_pc", i),   id_pc,            vt[i].e_idpc);
            chk($sformatf("dir%0d.plus4", i),   id_pc_plus4,      vt[i].e_idpc + 32'd4);
            chk($sformatf("dir%0d.valid", i),   32'(id_valid),    32'(vt[i].e_v));
            chk($sformatf("dir%0d.instr", i),   id_instr,         vt[i].e_instr);
            chk($sformatf("dir%0d.holding", i), 32'(holding),     32'(vt[i].e_hold));
            chk($sformatf("dir%0d.misal", i),   32'(fetch_misaligned), 32'(vt[i].e_mis));
        end

        for (int i = 0; i < 3000; i++) begin
            logic        r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFFFFF0 | (rpc & 32'hF);
            cycle(r, s, rd, rpc);
            chk("rnd.pc",      pc,                    m_pc);
            chk("rnd.id_pc",   id_pc,                 m_fpc);
            chk("rnd.plus4",   id_pc_plus4,           m_fpc + 32'd4);
            chk("rnd.valid",   32'(id_valid),         32'(m_v));
            chk("rnd.instr",   id_instr,              m_v ? memf(m_fpc) : NOPI);
            chk("rnd.holding", 32'(holding),          32'(m_held));
            chk("rnd.misal",   32'(fetch_misaligned), 32'(m_mis));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
